// File: rtl/bcd_clock_pkg.sv
// Shared constants and types for the BCD time-of-day counter.
// Reset hours depend on BCD_CLOCK_12H_EN (12h build) vs the default 24h build.
package bcd_clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [2:0] DIG_H_TENS  = 3'd0;
  localparam logic [2:0] DIG_H_UNITS = 3'd1;
  localparam logic [2:0] DIG_M_TENS  = 3'd2;
  localparam logic [2:0] DIG_M_UNITS = 3'd3;
  localparam logic [2:0] DIG_S_TENS  = 3'd4;
  localparam logic [2:0] DIG_S_UNITS = 3'd5;

  localparam bcd_t BCD_NINE  = 4'd9;
  localparam bcd_t BCD_FIVE  = 4'd5;
  localparam bcd_t BCD_THREE = 4'd3;
  localparam bcd_t BCD_TWO   = 4'd2;
  localparam bcd_t BCD_ONE   = 4'd1;

  localparam bcd_t RST_H_TENS_24  = 4'd0;
  localparam bcd_t RST_H_UNITS_24 = 4'd0;
  localparam bcd_t RST_H_TENS_12  = 4'd1;
  localparam bcd_t RST_H_UNITS_12 = 4'd2;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..i_max with increment enable, synchronous clear
// and carry-out. o_next exposes the value the digit takes at the next edge.
module bcd_digit
  import bcd_clock_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_inc,
  input  logic       i_clr,
  input  logic [3:0] i_max,
  output logic [3:0] o_val,
  output logic [3:0] o_next,
  output logic       o_carry
);

  bcd_t val_q, val_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    val_d   = val_q;
    o_carry = 1'b0;
    if (i_clr) begin
      val_d = '0;
    end else if (i_inc) begin
      // >= rather than == so a corrupted value still recovers into range
      if (val_q >= i_max) begin
        val_d   = '0;
        o_carry = 1'b1;
      end else begin
        val_d = val_q + 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) val_q <= '0;
    else       val_q <= val_d;
  end

  assign o_val  = val_q;
  assign o_next = val_d;

endmodule

// File: rtl/bcd_clock_counter.sv
// HH:MM:SS BCD time-of-day counter with set buttons and a multiplexed digit bus.
// Define BCD_CLOCK_12H_EN for the 12-hour build with PM indicator.
module bcd_clock_counter
  import bcd_clock_pkg::*;
#(
  parameter int TICK_DIV = 12500,
  parameter int SCAN_DIV = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_set_hours,
  input  logic       i_set_minutes,
  output logic [3:0] o_digit,
  output logic [2:0] o_digit_sel,
  output logic       o_tick,
  output logic       o_colon,
  output logic       o_pm
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

`ifdef BCD_CLOCK_12H_EN
  localparam bcd_t H_TENS_RST  = RST_H_TENS_12;
  localparam bcd_t H_UNITS_RST = RST_H_UNITS_12;
`else
  localparam bcd_t H_TENS_RST  = RST_H_TENS_24;
  localparam bcd_t H_UNITS_RST = RST_H_UNITS_24;
`endif

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [2:0]    sel_q, sel_d;
  bcd_t          digit_q, digit_d;
  bcd_t          ht_q, ht_d, hu_q, hu_d;
  logic          tick_q, tick_d, colon_q, colon_d;
  logic          set_h_prev_q, set_h_prev_d, set_m_prev_q, set_m_prev_d;

  logic ev_h, ev_m, presc_term, adv, hour_inc;
  logic su_c, st_c, mu_c, mt_c;
  bcd_t su, st, mu, mt, su_n, st_n, mu_n, mt_n;

  always_comb begin
    set_h_prev_d = i_set_hours;
    set_m_prev_d = i_set_minutes;
    ev_h         = i_set_hours & ~set_h_prev_q;
    ev_m         = i_set_minutes & ~set_m_prev_q;
    presc_term   = (presc_q == PRESC_LAST);
    // A set event swallows a coincident one-second advance
    adv          = presc_term & ~(ev_h | ev_m);
    // Minutes wrap from a set event never carries into hours
    hour_inc     = ev_h | (mt_c & ~ev_m);
    tick_d       = adv;
    presc_d      = (ev_m || presc_term) ? '0 : presc_q + PW'(1);
    colon_d      = (presc_d < PRESC_HALF);
  end

  bcd_digit u_s_units (.i_clk(i_clk), .i_rst(i_rst), .i_inc(adv),         .i_clr(ev_m),
                       .i_max(BCD_NINE), .o_val(su), .o_next(su_n), .o_carry(su_c));
  bcd_digit u_s_tens  (.i_clk(i_clk), .i_rst(i_rst), .i_inc(su_c),        .i_clr(ev_m),
                       .i_max(BCD_FIVE), .o_val(st), .o_next(st_n), .o_carry(st_c));
  bcd_digit u_m_units (.i_clk(i_clk), .i_rst(i_rst), .i_inc(st_c | ev_m), .i_clr(1'b0),
                       .i_max(BCD_NINE), .o_val(mu), .o_next(mu_n), .o_carry(mu_c));
  bcd_digit u_m_tens  (.i_clk(i_clk), .i_rst(i_rst), .i_inc(mu_c),        .i_clr(1'b0),
                       .i_max(BCD_FIVE), .o_val(mt), .o_next(mt_n), .o_carry(mt_c));

  always_comb begin
    ht_d = ht_q;
    hu_d = hu_q;
    if (hour_inc) begin
`ifdef BCD_CLOCK_12H_EN
      if (ht_q >= BCD_ONE && hu_q >= BCD_TWO) begin
        ht_d = '0;
        hu_d = BCD_ONE;
      end else if (hu_q >= BCD_NINE) begin
        ht_d = BCD_ONE;
        hu_d = '0;
      end else begin
        hu_d = hu_q + 4'd1;
      end
`else
      if (ht_q >= BCD_TWO && hu_q >= BCD_THREE) begin
        ht_d = '0;
        hu_d = '0;
      end else if (hu_q >= BCD_NINE) begin
        ht_d = ht_q + 4'd1;
        hu_d = '0;
      end else begin
        hu_d = hu_q + 4'd1;
      end
`endif
    end
  end

`ifdef BCD_CLOCK_12H_EN
  logic pm_q, pm_d;

  always_comb begin
    pm_d = pm_q;
    if (hour_inc && ht_q == BCD_ONE && hu_q == BCD_ONE) pm_d = ~pm_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pm_q <= 1'b0;
    else       pm_q <= pm_d;
  end

  assign o_pm = pm_q;
`else
  assign o_pm = 1'b0;
`endif

  // Digit bus follows the next-state index and next-state time together
  always_comb begin
    scan_d = scan_q + SW'(1);
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = (sel_q >= DIG_S_UNITS) ? DIG_H_TENS : sel_q + 3'd1;
    end
    case (sel_d)
      DIG_H_TENS:  digit_d = ht_d;
      DIG_H_UNITS: digit_d = hu_d;
      DIG_M_TENS:  digit_d = mt_n;
      DIG_M_UNITS: digit_d = mu_n;
      DIG_S_TENS:  digit_d = st_n;
      DIG_S_UNITS: digit_d = su_n;
      default:     digit_d = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc_q      <= '0;
      scan_q       <= '0;
      sel_q        <= DIG_H_TENS;
      digit_q      <= H_TENS_RST;
      ht_q         <= H_TENS_RST;
      hu_q         <= H_UNITS_RST;
      tick_q       <= 1'b0;
      colon_q      <= 1'b1;
      set_h_prev_q <= 1'b0;
      set_m_prev_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      scan_q       <= scan_d;
      sel_q        <= sel_d;
      digit_q      <= digit_d;
      ht_q         <= ht_d;
      hu_q         <= hu_d;
      tick_q       <= tick_d;
      colon_q      <= colon_d;
      set_h_prev_q <= set_h_prev_d;
      set_m_prev_q <= set_m_prev_d;
    end
  end

  assign o_digit     = digit_q;
  assign o_digit_sel = sel_q;
  assign o_tick      = tick_q;
  assign o_colon     = colon_q;

endmodule

// File: doc/bcd_clock_counter.md
Name: bcd_clock_counter

Overview:
Time-of-day counter for the clock display. Keeps HH:MM:SS as six BCD digits, advanced by an internal one-second prescaler, and accepts set-button pulses for hours and minutes. Multiplexes one digit at a time onto a 4-bit BCD bus with a digit index. The bus feeds the BCD-to-7-segment decoder directly; the index drives the digit anode select.

Parameters:
TICK_DIV, 12500, i_clk cycles per second (>=2)
SCAN_DIV, 64, i_clk cycles each digit stays selected on the scan bus (>=1)

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous, active-high reset
i_set_hours  input  1  set button, hours; level, synchronised upstream
i_set_minutes  input  1  set button, minutes; level, synchronised upstream
o_digit  output  4  BCD value of selected digit, to segment decoder
o_digit_sel  output  3  selected digit index 0..5 (0=H tens, 1=H units, 2=M tens, 3=M units, 4=S tens, 5=S units)
o_tick  output  1  one-cycle pulse on each one-second advance
o_colon  output  1  colon blink: high first half of each second
o_pm  output  1  PM indicator (12h build only, else 0)

Behaviour:
- Reset:
  - Interface: one clock i_clk; i_rst asynchronous, active-high.
  - Reset time: 00:00:00 (24h build) / 12:00:00 AM (12h build).
  - Prescaler=0, scan index=0, o_tick=0, o_colon=1, o_pm=0.
  - o_digit equals H-tens reset value (0 in 24h, 1 in 12h); o_digit_sel=0.
  - All outputs registered.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - At terminal count: wraps to 0, o_tick=1 next cycle for exactly one cycle, time advances by 1 s.
  - o_colon = (prescaler < TICK_DIV/2).
- Time cascade (registered, single cycle):
  - S units 0-9, carry into S tens 0-5.
  - Carry from 59 s into minutes, same structure.
  - Carry from 59 min into hours.
  - 24h: hours 00..23, H units wraps at 9, or at 3 when H tens=2. 23:59:59 -> 00:00:00 in one tick.
  - No digit ever holds a non-BCD or out-of-range value.
- Set buttons:
  - Rising-edge detected internally (one registered previous value each).
  - Held level produces exactly one event.
  - Minutes event: minutes+1 mod 60, no carry into hours; seconds cleared to 00; prescaler cleared to 0.
  - Hours event: hours+1 with normal wrap; minutes and seconds untouched; prescaler untouched.
  - Both events in the same cycle: both applied.
- Simultaneous events:
  - Set event coincident with prescaler terminal count: set applies, the 1-s advance is dropped, o_tick is not pulsed.
  - Minutes event also restarts the prescaler from 0.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1; at terminal, index advances 0->1->...->5->0.
  - o_digit is the registered value of the digit at the new index, updated in the same cycle as o_digit_sel. Sel and value never disagree.
  - o_digit reflects time updates within one cycle.
- Mid-operation reset returns all state to reset values immediately, regardless of clock.

Optional Feature:
BCD_CLOCK_12H_EN
- Defined:
  - Hours sequence 12,01,02..11,12.
  - o_pm toggles on the 11->12 transition, whether by tick carry or by set event.
  - Reset 12:00:00, o_pm=0.
  - H tens is 0 or 1 only.
- Undefined: 24h behaviour as above; o_pm tied 0.

Decomposition:
- Package bcd_clock_pkg:
  - Digit index constants (DIG_H_TENS..DIG_S_UNITS).
  - BCD limit constants (9, 5, 2, 3, 1).
  - Reset time constants per mode.
  - 4-bit bcd_t typedef.
- Sub-module bcd_digit: one BCD digit with programmable max, increment enable, synchronous clear, carry-out.
  - Instantiated for the four S/M digits.
  - Hours pair handled in the top level because of its mode-dependent wrap.

Test Plan:
- Reset with TICK_DIV=4, SCAN_DIV=1 -> o_digit_sel cycles 0..5 every cycle; o_digit all 0; o_tick first pulses 4 cycles after reset release.
- Preload via set buttons to 23:59:55, run 5 ticks -> 00:00:00 after the 5th tick; o_tick pulses exactly 5 times; no out-of-range digit observed.
- Hold i_set_hours high 20 cycles at 23:10:30 -> exactly one event, time 00:10:30.
- Pulse i_set_minutes in the prescaler terminal cycle at 00:59:42 -> time 00:00:00 (hours unchanged); no o_tick that cycle; next o_tick TICK_DIV cycles later.
- Assert i_rst mid-second and mid-scan at 14:27:33 -> outputs at reset values asynchronously; counting resumes from 00:00:00.
- BCD_CLOCK_12H_EN defined: advance 11:59:59 AM by one tick -> 12:00:00, o_pm=1; hours event from 12 -> 01, o_pm unchanged.
